// File: rtl/counter_monitor.sv
// Watches an external up/down counter, tracks its expected value and
// scores each observed count against that prediction until NUM_CHECKS compares.
//
// state  | meaning
// IDLE   | waiting for the observed counter to be reset
// SYNC   | observed counter in reset, model tracking, no compares
// CHECK  | one compare per cycle against the model
// DONE   | run complete, everything frozen until rst
module counter_monitor #(
  parameter int WIDTH      = 4,
  parameter int NUM_CHECKS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m_rst_n,
  input  logic             m_en,
  input  logic             m_up_dn,
  input  logic [WIDTH-1:0] m_count,
  output logic [WIDTH-1:0] exp_count,
  output logic             mismatch,
  output logic [7:0]       err_cnt,
  output logic [15:0]      chk_cnt,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_act,
  output logic             done,
  output logic             pass
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SYNC  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [15:0] CHK_LAST = 16'(NUM_CHECKS);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] exp_nxt;
  logic [15:0]      chk_inc;
  logic             cmp_fail;

  always_comb begin
    exp_nxt = exp_count;
    if (!m_rst_n)
      exp_nxt = '0;
    else if (m_en)
      exp_nxt = m_up_dn ? exp_count + WIDTH'(1) : exp_count - WIDTH'(1);
  end

  assign chk_inc  = chk_cnt + 16'd1;
  assign cmp_fail = (state == S_CHECK) && (m_count != exp_count);

  // Reaching the compare budget wins over a concurrent observed-counter reset.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!m_rst_n) state_nxt = S_SYNC;
      S_SYNC:  if (m_rst_n) state_nxt = S_CHECK;
      S_CHECK: begin
        if (chk_inc == CHK_LAST)
          state_nxt = S_DONE;
        else if (!m_rst_n)
          state_nxt = S_SYNC;
      end
      default: state_nxt = S_DONE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      exp_count     <= '0;
      mismatch      <= 1'b0;
      err_cnt       <= 8'd0;
      chk_cnt       <= 16'd0;
      first_err_exp <= '0;
      first_err_act <= '0;
    end else begin
      state    <= state_nxt;
      mismatch <= cmp_fail;
      if (state == S_SYNC || state == S_CHECK)
        exp_count <= exp_nxt;
      if (state == S_CHECK)
        chk_cnt <= chk_inc;
      if (cmp_fail) begin
        if (err_cnt != 8'hFF)
          err_cnt <= err_cnt + 8'd1;
        // err_cnt never returns to zero once counting, so zero marks the first failure
        if (err_cnt == 8'd0) begin
          first_err_exp <= exp_count;
          first_err_act <= m_count;
        end
      end
    end
  end

  assign done = (state == S_DONE);
  assign pass = done && (err_cnt == 8'd0);

endmodule

// File: tb/tb_counter_monitor.sv
// Bench for counter_monitor: two instances (short and long compare budgets)
// driven by the same stimulus and scored against a per-cycle arithmetic model.
module tb_counter_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_rst_n = 1'b1;
  logic       m_en = 1'b0;
  logic       m_up_dn = 1'b1;
  logic [3:0] m_count = 4'd0;

  logic [3:0]  e0, fe0, fa0, e1, fe1, fa1;
  logic        mm0, d0, p0, mm1, d1, p1;
  logic [7:0]  ec0, ec1;
  logic [15:0] cc0, cc1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  counter_monitor #(.WIDTH(4), .NUM_CHECKS(16)) dut (
    .clk(clk), .rst(rst), .m_rst_n(m_rst_n), .m_en(m_en), .m_up_dn(m_up_dn),
    .m_count(m_count), .exp_count(e0), .mismatch(mm0), .err_cnt(ec0),
    .chk_cnt(cc0), .first_err_exp(fe0), .first_err_act(fa0), .done(d0), .pass(p0)
  );

  counter_monitor #(.WIDTH(4), .NUM_CHECKS(320)) dut_long (
    .clk(clk), .rst(rst), .m_rst_n(m_rst_n), .m_en(m_en), .m_up_dn(m_up_dn),
    .m_count(m_count), .exp_count(e1), .mismatch(mm1), .err_cnt(ec1),
    .chk_cnt(cc1), .first_err_exp(fe1), .first_err_act(fa1), .done(d1), .pass(p1)
  );

  // Model: index 0 follows dut, index 1 follows dut_long.
  int ncheck[2] = '{16, 320};
  int mexp[2], mchk[2], merr[2], mfe[2], mfa[2];
  bit mmis[2], started[2], checking[2], finished[2];

  task automatic check_val(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      mexp[i] = 0; mchk[i] = 0; merr[i] = 0; mfe[i] = 0; mfa[i] = 0;
      mmis[i] = 0; started[i] = 0; checking[i] = 0; finished[i] = 0;
    end
  endfunction

  function automatic void model_edge(int i, bit rn, bit en, bit up, int cnt);
    int nxt;
    nxt = !rn ? 0 : (en ? (up ? (mexp[i] + 1) % 16 : (mexp[i] + 15) % 16) : mexp[i]);
    mmis[i] = 0;
    if (finished[i]) return;
    if (checking[i]) begin
      mchk[i]++;
      if (cnt != mexp[i]) begin
        mmis[i] = 1;
        if (merr[i] == 0) begin
          mfe[i] = mexp[i];
          mfa[i] = cnt;
        end
        if (merr[i] < 255) merr[i]++;
      end
      mexp[i] = nxt;
      if (mchk[i] == ncheck[i]) finished[i] = 1;
      else if (!rn) checking[i] = 0;
    end else if (started[i]) begin
      mexp[i] = nxt;
      if (rn) checking[i] = 1;
    end else if (!rn) begin
      started[i] = 1;
    end
  endfunction

  task automatic check_outs();
    check_val("exp_count0", int'(e0), mexp[0]);
    check_val("mismatch0", int'(mm0), int'(mmis[0]));
    check_val("err_cnt0", int'(ec0), merr[0]);
    check_val("chk_cnt0", int'(cc0), mchk[0]);
    check_val("first_exp0", int'(fe0), mfe[0]);
    check_val("first_act0", int'(fa0), mfa[0]);
    check_val("done0", int'(d0), int'(finished[0]));
    check_val("pass0", int'(p0), int'(finished[0] && merr[0] == 0));
    check_val("exp_count1", int'(e1), mexp[1]);
    check_val("mismatch1", int'(mm1), int'(mmis[1]));
    check_val("err_cnt1", int'(ec1), merr[1]);
    check_val("chk_cnt1", int'(cc1), mchk[1]);
    check_val("first_exp1", int'(fe1), mfe[1]);
    check_val("first_act1", int'(fa1), mfa[1]);
    check_val("done1", int'(d1), int'(finished[1]));
    check_val("pass1", int'(p1), int'(finished[1] && merr[1] == 0));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then sample.
  task automatic step(input bit rn, input bit en, input bit up, input int cnt);
    m_rst_n = rn;
    m_en    = en;
    m_up_dn = up;
    m_count = 4'(cnt);
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_edge(i, rn, en, up, cnt);
    #1;
    check_outs();
  endtask

  // Asynchronous reset pulse between edges; outputs must clear before the next edge.
  task automatic rst_pulse();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outs();
    #1 rst = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outs();
    @(negedge clk);
    rst = 1'b0;

    // Clean run: one cycle of observed reset, up x3, down x3, then correct traffic.
    step(0, 0, 1, 0);
    repeat (3) step(1, 1, 1, mexp[0]);
    repeat (3) step(1, 1, 0, mexp[0]);
    check_val("clean_back_to_zero", int'(e0), 0);
    for (int k = 0; k < 20; k++)
      step(1, 1'($urandom), 1'($urandom), mexp[0]);
    check_val("clean_pass", int'(p0), 1);

    // Wrap both ways, injected error, observed reset mid-check.
    rst_pulse();
    step(0, 1, 1, 0);
    step(1, 1, 0, mexp[0]);
    check_val("wrap_down", int'(e0), 15);
    step(1, 1, 1, mexp[0]);
    check_val("wrap_up", int'(e0), 0);
    for (int k = 0; k < 4; k++) step(1, 1, 1, mexp[0]);
    step(1, 0, 1, 5);
    check_val("inj_mismatch", int'(mm0), 1);
    check_val("inj_first_exp", int'(fe0), 4);
    check_val("inj_first_act", int'(fa0), 5);
    step(1, 0, 1, mexp[0]);
    check_val("inj_pulse_end", int'(mm0), 0);
    repeat (3) step(0, 1, 1, mexp[0]);
    step(1, 1, 1, mexp[0]);
    for (int k = 0; k < 12; k++) step(1, 1'($urandom), 1'($urandom), mexp[0]);
    check_val("inj_pass_low", int'(p0), 0);
    check_val("inj_done", int'(d0), 1);

    // Randomized runs, each interrupted by an asynchronous reset pulse.
    for (int r = 0; r < 6; r++) begin
      rst_pulse();
      step(0, 1'($urandom), 1'($urandom), 0);
      for (int k = 0; k < 40; k++)
        step(($urandom % 10) != 0, 1'($urandom), 1'($urandom),
             ($urandom % 8 == 0) ? int'($urandom % 16) : mexp[1]);
    end

    // Persistent mismatches on the long instance: err_cnt saturates.
    rst_pulse();
    step(0, 0, 1, 0);
    for (int k = 0; k < 310; k++)
      step(1, 1'($urandom), 1'($urandom), (mexp[1] + 1) % 16);
    check_val("sat_err_cnt", int'(ec1), 255);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/counter_monitor.md
COUNTER_MONITOR -- requirements
Module: counter_monitor

Interface
REQ-001 Parameter: WIDTH, default 4, bit width of the observed up/down counter.
REQ-002 Parameter: NUM_CHECKS, default 16, number of compares in one run before done.
REQ-003 clk  input  1  single clock; all sampling on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 m_rst_n  input  1  observed counter reset, synchronous, active-low.
REQ-006 m_en  input  1  observed counter enable.
REQ-007 m_up_dn  input  1  observed direction; 1 = up, 0 = down.
REQ-008 m_count  input  WIDTH  observed counter output.
REQ-009 exp_count  output  WIDTH  reference-model expected count.
REQ-010 mismatch  output  1  one-cycle pulse per failed compare.
REQ-011 err_cnt  output  8  saturating count of failed compares.
REQ-012 chk_cnt  output  16  count of compares performed.
REQ-013 first_err_exp / first_err_act  output  WIDTH each  expected and actual values at the first failure.
REQ-014 done  output  1  high once chk_cnt reaches NUM_CHECKS.
REQ-015 pass  output  1  high when done and err_cnt == 0.

Function
REQ-016 State machine with states IDLE, SYNC, CHECK and DONE; state SHALL be IDLE after reset.
REQ-017 IDLE: exp_count held at 0; no compares; go to SYNC on the edge where m_rst_n is sampled 0.
REQ-018 SYNC: no compares; go to CHECK on the edge where m_rst_n is sampled 1.
REQ-019 CHECK: one compare per cycle; go to SYNC if m_rst_n is sampled 0; go to DONE when chk_cnt reaches NUM_CHECKS.
REQ-020 DONE: terminal until rst; model stops updating; no compares; all outputs hold.
REQ-021 Model update in SYNC and CHECK, every edge:
- m_rst_n == 0: exp_count <= 0.
- else m_en == 1: exp_count <= exp_count +1 (m_up_dn = 1) or -1 (m_up_dn = 0), modulo 2^WIDTH.
- else: hold.
REQ-022 Wrap-around: up from 2^WIDTH-1 gives 0; down from 0 gives 2^WIDTH-1; neither is an error.
REQ-023 Compare in CHECK: sampled m_count against the current exp_count register value, before that edge's model update; chk_cnt increments by 1.
REQ-024 On compare failure: mismatch asserted for exactly the following cycle; err_cnt +1, saturating at 255.
REQ-025 first_err_exp/first_err_act are loaded only on the first failure after reset and are never overwritten.
REQ-026 The SYNC->CHECK transition edge performs the model update but no compare; the first compare occurs on the next edge.
REQ-027 m_rst_n low mid-CHECK: chk_cnt and err_cnt are retained; the model is forced to 0 as in REQ-021.
REQ-028 If the edge that performs compare NUM_CHECKS also samples m_rst_n == 0, DONE takes priority.
REQ-029 pass is combinational from done and err_cnt == 0; pass is 0 whenever done is 0.

Reset
REQ-030 rst asserted: all registers clear immediately, regardless of clk.
REQ-031 While rst is high, all outputs read 0: exp_count, mismatch, err_cnt, chk_cnt, first_err_*, done, pass.
REQ-032 After rst is released, the block restarts in IDLE and waits for a fresh m_rst_n low.

Verification
REQ-033 Clean run: m_rst_n low 1 cycle, then up x3 and down x3 with a correct m_count -> exp_count 1,2,3,2,1,0; mismatch never asserted; after 16 compares done=1, pass=1.
REQ-034 Wrap: WIDTH=4, count up from 15 -> exp_count 0; count down from 0 -> exp_count 15; err_cnt stays 0.
REQ-035 Injected error: m_count=5 while exp_count=4 -> mismatch high exactly one cycle later; err_cnt=1; first_err_exp=4, first_err_act=5; at done pass=0.
REQ-036 m_rst_n low for 3 cycles mid-CHECK -> state SYNC; exp_count=0; chk_cnt frozen; compares resume one edge after m_rst_n returns high.
REQ-037 rst pulsed between clock edges mid-run -> all outputs 0 before the next posedge; state IDLE.
REQ-038 300 consecutive mismatches -> err_cnt saturates at 255; first_err_* hold the first failing pair.
